// File: rtl/security_arm_controller.sv
// security_arm_controller: 4-digit code sequencer driving the arm/entry/alarm state machine
// with exit and entry delays and a consecutive-failure alarm.
module security_arm_controller #(
    parameter logic [1:0]  CODE_0       = 2'b01,
    parameter logic [1:0]  CODE_1       = 2'b10,
    parameter logic [1:0]  CODE_2       = 2'b11,
    parameter logic [1:0]  CODE_3       = 2'b00,
    parameter int unsigned EXIT_CYCLES  = 16,
    parameter int unsigned ENTRY_CYCLES = 16,
    parameter int unsigned MAX_FAIL     = 3
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic [1:0] i_Input_State,
    input  logic       i_Enter,
    input  logic       i_Sensor,
    output logic [2:0] o_State,
    output logic       o_Armed,
    output logic       o_Warn,
    output logic       o_Alarm,
    output logic [1:0] o_Digit_Count,
    output logic [2:0] o_Fail_Count
);
    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    localparam logic [15:0] EXIT_LOAD  = 16'(EXIT_CYCLES - 1);
    localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_CYCLES - 1);
    localparam logic [3:0]  FAIL_MAX   = 4'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  fail_q, fail_d;
    logic        match_q, match_d;
    logic        enter_q;
    logic        code_ok_q, code_ok_d;
    logic        code_bad_q, code_bad_d;
    logic [1:0]  want;
    logic [3:0]  fail_inc;
    logic        accept, hit, guarded, expired;

    // Code entry: the verdict is registered on the 4th accept and acted on one edge later.
    always_comb begin
        want       = idx_q == 2'd0 ? CODE_0 : idx_q == 2'd1 ? CODE_1 : idx_q == 2'd2 ? CODE_2 : CODE_3;
        accept     = i_Enter & ~enter_q;
        hit        = match_q & (i_Input_State == want);
        idx_d      = accept ? idx_q + 2'd1 : idx_q;
        match_d    = accept ? ((idx_q == 2'd3) | hit) : match_q;
        code_ok_d  = accept & (idx_q == 2'd3) & hit;
        code_bad_d = accept & (idx_q == 2'd3) & ~hit;
    end

    always_comb begin
        guarded  = state_q == ARMED || state_q == ENTRY;
        expired  = timer_q == 16'd0;
        fail_inc = {1'b0, fail_q} + 4'd1;
        state_d  = state_q;
        fail_d   = fail_q;
        timer_d  = expired ? timer_q : timer_q - 16'd1;
        if (code_bad_q && guarded)
            fail_d = fail_inc >= FAIL_MAX ? FAIL_MAX[2:0] : fail_inc[2:0];
        if (code_ok_q)
            state_d = state_q == DISARMED ? ARMING : DISARMED;
        else if (code_bad_q && guarded && fail_inc >= FAIL_MAX)
            state_d = ALARM;
        else if (expired && state_q == ARMING)
            state_d = ARMED;
        else if (expired && state_q == ENTRY)
            state_d = ALARM;
        else if (state_q == ARMED && i_Sensor)
            state_d = ENTRY;
        if (state_d != state_q)
            timer_d = state_d == ARMING ? EXIT_LOAD : state_d == ENTRY ? ENTRY_LOAD : timer_d;
        if (code_ok_q || (state_d != state_q && (state_d == ARMED || state_d == DISARMED)))
            fail_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= DISARMED;
            timer_q    <= '0;
            idx_q      <= '0;
            match_q    <= 1'b1;
            enter_q    <= 1'b0;
            code_ok_q  <= 1'b0;
            code_bad_q <= 1'b0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            match_q    <= match_d;
            enter_q    <= i_Enter;
            code_ok_q  <= code_ok_d;
            code_bad_q <= code_bad_d;
            fail_q     <= fail_d;
        end
    end

    assign o_State       = state_q;
    assign o_Armed       = state_q == ARMED || state_q == ENTRY;
    assign o_Warn        = state_q == ARMING || state_q == ENTRY;
    assign o_Alarm       = state_q == ALARM;
    assign o_Digit_Count = idx_q;
    assign o_Fail_Count  = fail_q;
endmodule

// File: tb/tb_security_arm_controller.sv
// tb_security_arm_controller: scenario tasks plus randomized stimulus checked against a
// timestamp-based reference model of the arm/entry/alarm rules.
module tb_security_arm_controller;
    localparam int C0 = 1, C1 = 2, C2 = 3, C3 = 0;
    localparam int EXIT = 16, ENTRY = 16, MAXF = 3;

    logic       i_Clk = 1'b0;
    logic       i_Reset_n = 1'b0;
    logic [1:0] i_Input_State = 2'd0;
    logic       i_Enter = 1'b0;
    logic       i_Sensor = 1'b0;
    logic [2:0] o_State;
    logic       o_Armed, o_Warn, o_Alarm;
    logic [1:0] o_Digit_Count;
    logic [2:0] o_Fail_Count;
    logic [10:0] dut_vec;

    int n_cmp = 0;
    int n_fail = 0;

    security_arm_controller #(
        .CODE_0(2'b01), .CODE_1(2'b10), .CODE_2(2'b11), .CODE_3(2'b00),
        .EXIT_CYCLES(EXIT), .ENTRY_CYCLES(ENTRY), .MAX_FAIL(MAXF)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset_n(i_Reset_n),
        .i_Input_State(i_Input_State),
        .i_Enter(i_Enter),
        .i_Sensor(i_Sensor),
        .o_State(o_State),
        .o_Armed(o_Armed),
        .o_Warn(o_Warn),
        .o_Alarm(o_Alarm),
        .o_Digit_Count(o_Digit_Count),
        .o_Fail_Count(o_Fail_Count)
    );

    always #5 i_Clk = ~i_Clk;

    assign dut_vec = {o_State, o_Armed, o_Warn, o_Alarm, o_Digit_Count, o_Fail_Count};

    // Reference model: states as plain ints, delays as absolute deadline cycle numbers,
    // the partial code as a queue of entered digits.
    int code_tbl[4] = '{C0, C1, C2, C3};
    int m_state, m_fail, m_cyc, m_deadline;
    int m_digits[$];
    bit m_prev_enter, m_ok, m_bad;

    task automatic model_reset();
        m_state = 0; m_fail = 0; m_deadline = 0;
        m_digits.delete();
        m_prev_enter = 0; m_ok = 0; m_bad = 0;
    endtask

    task automatic model_update();
        int nxt;
        bit guarded;
        m_cyc++;
        nxt = m_state;
        guarded = (m_state == 2 || m_state == 3);
        if (m_ok) begin
            nxt = (m_state == 0) ? 1 : 0;
            m_fail = 0;
        end else begin
            if (m_bad && guarded) m_fail = (m_fail + 1 >= MAXF) ? MAXF : m_fail + 1;
            if (m_bad && guarded && m_fail == MAXF) nxt = 4;
            else if (m_state == 1 && m_cyc == m_deadline) nxt = 2;
            else if (m_state == 3 && m_cyc == m_deadline) nxt = 4;
            else if (m_state == 2 && i_Sensor) nxt = 3;
        end
        if (nxt != m_state) begin
            if (nxt == 1) m_deadline = m_cyc + EXIT;
            if (nxt == 3) m_deadline = m_cyc + ENTRY;
            if (nxt == 0 || nxt == 2) m_fail = 0;
        end
        m_state = nxt;
        m_ok = 0; m_bad = 0;
        if (i_Enter && !m_prev_enter) m_digits.push_back(int'(i_Input_State));
        if (m_digits.size() == 4) begin
            m_ok = (m_digits[0] == C0 && m_digits[1] == C1 && m_digits[2] == C2 && m_digits[3] == C3);
            m_bad = !m_ok;
            m_digits.delete();
        end
        m_prev_enter = i_Enter;
    endtask

    function automatic logic [10:0] exp_vec();
        return {3'(m_state), m_state == 2 || m_state == 3, m_state == 1 || m_state == 3,
                m_state == 4, 2'(m_digits.size()), 3'(m_fail)};
    endfunction

    task automatic tick(input logic [1:0] d, input logic en, input logic sen);
        i_Input_State = d; i_Enter = en; i_Sensor = sen;
        @(posedge i_Clk);
        model_update();
        @(negedge i_Clk);
    endtask

    task automatic press(input int d);
        tick(2'(d), 1'b1, 1'b0);
        tick(2'($urandom), 1'b0, 1'b0);
    endtask

    task automatic code4(input int a, input int b, input int c, input int e);
        press(a); press(b); press(c); press(e);
    endtask

    task automatic arm();
        code4(C0, C1, C2, C3);
        repeat (EXIT) tick(2'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_Reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_Input_State = 2'($urandom); i_Enter = 1'($urandom); i_Sensor = 1'($urandom);
            @(negedge i_Clk);
            n_cmp++;
            if (dut_vec !== 11'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 000", dut_vec); end
        end
        i_Enter = 1'b0; i_Reset_n = 1'b1;
        model_reset();
        press(C0); press(C1); press(C2);
        tick(2'(C3), 1'b1, 1'b0);
        n_cmp++;
        if (o_State !== 3'd0) begin n_fail++; $display("FAIL arm_latency_early: got %0d want 0", o_State); end
        tick(2'($urandom), 1'b0, 1'b0);
        n_cmp++;
        if (o_State !== 3'd1 || o_Warn !== 1'b1) begin n_fail++; $display("FAIL arm_latency: got %0d/%b want 1/1", o_State, o_Warn); end
        for (int i = 0; i < EXIT - 1; i++) begin
            tick(2'($urandom), 1'b0, 1'($urandom));
            n_cmp++;
            if (o_State !== 3'd1) begin n_fail++; $display("FAIL exit_hold[%0d]: got %0d want 1", i, o_State); end
        end
        tick(2'($urandom), 1'b0, 1'b0);
        n_cmp++;
        if (o_State !== 3'd2 || o_Armed !== 1'b1) begin n_fail++; $display("FAIL exit_done: got %0d/%b want 2/1", o_State, o_Armed); end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL arm_model: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_entry();
        tick(2'($urandom), 1'b0, 1'b1);
        n_cmp++;
        if (o_State !== 3'd3 || o_Warn !== 1'b1) begin n_fail++; $display("FAIL entry_start: got %0d/%b want 3/1", o_State, o_Warn); end
        for (int i = 0; i < ENTRY - 1; i++) begin
            tick(2'($urandom), 1'b0, 1'($urandom));
            n_cmp++;
            if (o_State !== 3'd3) begin n_fail++; $display("FAIL entry_hold[%0d]: got %0d want 3", i, o_State); end
        end
        tick(2'($urandom), 1'b0, 1'b0);
        n_cmp++;
        if (o_State !== 3'd4 || o_Alarm !== 1'b1) begin n_fail++; $display("FAIL entry_expire: got %0d/%b want 4/1", o_State, o_Alarm); end
        code4(C0, C1, C2, C3);
        n_cmp++;
        if (o_State !== 3'd0 || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL alarm_disarm: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_disarm_in_time();
        arm();
        tick(2'($urandom), 1'b0, 1'b1);
        n_cmp++;
        if (o_State !== 3'd3) begin n_fail++; $display("FAIL late_entry: got %0d want 3", o_State); end
        repeat (8) tick(2'($urandom), 1'b0, 1'b0);
        press(C0); press(C1); press(C2);
        tick(2'(C3), 1'b1, 1'b0);
        n_cmp++;
        if (o_State !== 3'd3) begin n_fail++; $display("FAIL late_pre: got %0d want 3", o_State); end
        tick(2'($urandom), 1'b0, 1'b0);
        n_cmp++;
        if (o_State !== 3'd0 || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL late_disarm: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_fail();
        arm();
        for (int k = 1; k <= MAXF; k++) begin
            code4(C3, C3, C3, C3);
            n_cmp++;
            if (o_Fail_Count !== 3'(k) || o_State !== (k == MAXF ? 3'd4 : 3'd2)) begin
                n_fail++; $display("FAIL armed_wrong[%0d]: got cnt %0d st %0d want cnt %0d", k, o_Fail_Count, o_State, k);
            end
        end
        code4(C0, C1, C2, C3);
        n_cmp++;
        if (o_State !== 3'd0 || o_Fail_Count !== 3'd0) begin n_fail++; $display("FAIL fail_clear: got %h want %h", dut_vec, exp_vec()); end
        for (int k = 0; k < MAXF; k++) begin
            code4(C3, C3, C3, C3);
            n_cmp++;
            if (o_Fail_Count !== 3'd0 || o_State !== 3'd0) begin n_fail++; $display("FAIL disarmed_wrong[%0d]: got %h want %h", k, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_edge_cancel();
        repeat (10) tick(2'(C0), 1'b1, 1'b0);
        n_cmp++;
        if (o_Digit_Count !== 2'd1) begin n_fail++; $display("FAIL enter_hold: got %0d want 1", o_Digit_Count); end
        tick(2'($urandom), 1'b0, 1'b0);
        press(C1); press(C2); press(C3);
        n_cmp++;
        if (o_State !== 3'd1) begin n_fail++; $display("FAIL held_code_arm: got %0d want 1", o_State); end
        code4(C0, C1, C2, C3);
        n_cmp++;
        if (o_State !== 3'd0) begin n_fail++; $display("FAIL arming_cancel: got %0d want 0", o_State); end
        repeat (EXIT + 4) tick(2'($urandom), 1'b0, 1'($urandom));
        n_cmp++;
        if (o_State !== 3'd0 || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cancel_stays: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_async_reset();
        code4(C0, C1, C2, C3);
        press(C0); press(C1);
        n_cmp++;
        if (o_State !== 3'd1 || o_Digit_Count !== 2'd2) begin n_fail++; $display("FAIL pre_reset: got %h want %h", dut_vec, exp_vec()); end
        #2 i_Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 11'd0) begin n_fail++; $display("FAIL async_reset: got %h want 000", dut_vec); end
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : code_tbl[m_digits.size()];
            tick(2'(d), 1'($urandom), $urandom_range(0, 9) == 0);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        test_reset();
        test_entry();
        test_disarm_in_time();
        test_fail();
        test_edge_cancel();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/security_arm_controller.md
Name: security_arm_controller

Overview:
- Sequencing controller for the security system. It consumes the 2-bit switch code from the switch-state decoder and a debounced enter button.
- It checks a 4-digit code sequence and drives the arm/disarm/alarm state machine, with an exit delay and an entry delay.
- It sits between the switch-state decoder and the alarm/LED outputs.

Parameters:
- CODE_0, 2'b01, first code digit
- CODE_1, 2'b10, second code digit
- CODE_2, 2'b11, third code digit
- CODE_3, 2'b00, fourth code digit
- EXIT_CYCLES, 16, exit-delay length in clocks; legal range 1..65535
- ENTRY_CYCLES, 16, entry-delay length in clocks; legal range 1..65535
- MAX_FAIL, 3, consecutive wrong codes while armed that force ALARM; legal range 1..7

Ports:
- i_Clk  input  1  system clock; all flops on rising edge
- i_Reset_n  input  1  asynchronous, active-low reset
- i_Input_State  input  2  current switch code from the switch-state decoder
- i_Enter  input  1  debounced enter button, level; the block edge-detects it
- i_Sensor  input  1  intrusion sensor, level, active-high
- o_State  output  3  state encoding: DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4
- o_Armed  output  1  high in ARMED or ENTRY
- o_Warn  output  1  high in ARMING or ENTRY
- o_Alarm  output  1  high in ALARM
- o_Digit_Count  output  2  number of digits entered in the current code attempt
- o_Fail_Count  output  3  consecutive failed attempts, saturates at MAX_FAIL

Behaviour:
- Reset (i_Reset_n=0, async):
  - state=DISARMED, timer=0, digit index=0, match flag=1, enter_q=0, code_ok=0, code_bad=0, fail count=0.
  - All outputs are therefore 0.
- Enter edge:
  - enter_q registers i_Enter.
  - A digit is accepted at clock edge N when i_Enter=1 and enter_q=0.
  - Holding i_Enter high yields exactly one digit.
- Digit accept:
  - match flag &= (i_Input_State == CODE[idx]); idx increments.
  - On the 4th accept (idx=3):
    - code_ok (if all 4 digits matched) or code_bad (otherwise) is registered high for one cycle at edge N.
    - idx returns to 0 and match flag returns to 1.
  - Digits are accepted in every state.
- Timing: the state update caused by code_ok/code_bad happens at edge N+1, i.e. 2 edges after i_Enter is first sampled high.
- Timer: 16-bit down-counter, loaded with X_CYCLES-1 on entry to ARMING or ENTRY, decrementing each cycle. Expiry is timer==0 while in that state, so the state is held for exactly X_CYCLES clocks.
- Transitions (evaluated each edge; priority order code_ok > fail limit > timer expiry > sensor):
  - DISARMED: code_ok -> ARMING.
  - ARMING: code_ok -> DISARMED (cancel); expiry -> ARMED; i_Sensor ignored.
  - ARMED: code_ok -> DISARMED; i_Sensor=1 -> ENTRY.
  - ENTRY: code_ok -> DISARMED; expiry -> ALARM; i_Sensor further ignored.
  - ALARM: code_ok -> DISARMED only; otherwise held.
- Fail count:
  - Increments on code_bad only in ARMED or ENTRY, saturating at MAX_FAIL.
  - When the incremented value reaches MAX_FAIL in ARMED/ENTRY, the state goes -> ALARM on the same edge as the increment.
  - Cleared on code_ok and on any transition into ARMED or DISARMED.
  - code_bad in DISARMED/ARMING/ALARM has no effect on the count.
- Simultaneous events:
  - code_ok on the same edge as timer expiry or i_Sensor: code_ok wins.
  - Sensor asserted on the ARMING->ARMED edge: not seen until the next edge.
- Outputs are pure decodes of registered state/counters, so they are glitch-free.
- Reset mid-operation (mid-code entry or mid-delay) returns everything to the reset values immediately; a partial code is discarded.

Test Plan:
- Reset values: hold i_Reset_n=0 with random inputs -> o_State=0 and all outputs 0. Release, then enter 01,10,11,00 -> o_State=1 exactly 2 edges after the 4th i_Enter sample, then o_State=2 after 16 further clocks, o_Armed=1.
- Entry path: from ARMED, pulse i_Sensor for 1 cycle -> o_State=3, o_Warn=1; with no code -> o_State=4, o_Alarm=1 exactly 16 clocks later. Then enter the correct code -> o_State=0.
- Disarm in time: in ENTRY, complete the correct code with code_ok landing on the timer==0 edge -> o_State=0 (not 4).
- Failed attempts: in ARMED, enter 00,00,00,00 three times -> o_Fail_Count 1,2,3 and o_State=4 on the edge of the third code_bad. In DISARMED, the same wrong codes leave o_Fail_Count=0.
- Edge detect and cancel: hold i_Enter high for 10 cycles -> o_Digit_Count increments once. In ARMING, enter the correct code before expiry -> o_State=0 and the timer does not reach ARMED.
- Async reset mid-entry: after 2 digits, assert i_Reset_n between clock edges -> o_Digit_Count=0 and o_State=0 immediately (no clock needed).
